// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the 16-bit processor. It owns PC and IR, runs the
//   FETCH / DECODE / EXEC / MEM / WB phases, handshakes with variable-latency
//   instruction and data memories, and drives the datapath control lines.
//   Optional build macro: PERF_CNT_EN adds the cycle_cnt / instr_cnt counters.
module multicycle_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   ir_out,
  output logic [PC_W-1:0] pc_out,
  input  logic            alu_zero,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            regdest,
  output logic            alusrc,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            memread,
  output logic            memwrite,
  output logic            branch,
  output logic            jump,
  output logic            retire,
  output logic [2:0]      state_out
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Instruction classes; every opcode maps to exactly one of these.
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_J,
    CLS_BR
  } cls_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  cls_t            cls;
  logic [PC_W-1:0] pc_inc;
  logic            retire_int;
  logic            static_en;

  // PC increment wraps naturally at the PC width.
  assign pc_inc = pc_q + PC_W'(1);

  // Classify the opcode held in IR[3:0].
  always_comb begin
    case (ir_q[3:0])
      4'd5, 4'd6:   cls = CLS_I;
      4'd7:         cls = CLS_LW;
      4'd8:         cls = CLS_SW;
      4'd9:         cls = CLS_J;
      4'd10, 4'd11: cls = CLS_BR;
      default:      cls = CLS_R;
    endcase
  end

  // Next-state, PC/IR update and retire detection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    retire_int = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_BR: begin
            pc_d       = alu_zero ? branch_target : pc_inc;
            retire_int = 1'b1;
          end
          CLS_J: begin
            pc_d       = jump_target;
            retire_int = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls == CLS_LW) begin
            state_d = S_WB;
          end else begin
            pc_d       = pc_inc;
            retire_int = 1'b1;
          end
        end
      end
      S_WB: begin
        pc_d       = pc_inc;
        retire_int = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // run is only consulted at an instruction boundary.
    if (retire_int) state_d = run ? S_FETCH : S_IDLE;
  end

  // State, PC and IR registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Datapath controls: static ones from IR after decode, phase-specific ones per state.
  always_comb begin
    regdest   = 1'b0;
    alusrc    = 1'b0;
    memtoreg  = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    static_en = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};
    if (static_en) begin
      case (cls)
        CLS_I:  begin regdest = 1'b1; alusrc = 1'b1; end
        CLS_LW: begin alusrc = 1'b1; memtoreg = 1'b1; end
        CLS_SW: alusrc = 1'b1;
        CLS_J:  jump = 1'b1;
        CLS_BR: branch = 1'b1;
        default: regdest = 1'b1;
      endcase
    end
    imem_req = (state_q == S_FETCH);
    dmem_req = (state_q == S_MEM);
    memread  = (state_q == S_MEM) && (cls == CLS_LW);
    memwrite = (state_q == S_MEM) && (cls == CLS_SW);
    dmem_we  = memwrite;
    regwrite = (state_q == S_WB);
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign retire    = retire_int;
  assign state_out = state_q;

`ifdef PERF_CNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  // Busy-cycle and retired-instruction counters, both wrapping at 16 bits.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_IDLE) cycle_cnt_d = cycle_cnt_q + 16'd1;
    if (retire_int)        instr_cnt_d = instr_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  // Counters not built: no extra state or ports.
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: directed scenarios plus randomized
// instruction streams, checked every cycle against an instruction-level model.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        alu_zero = 1'b0;
  logic [7:0]  branch_target = '0;
  logic [7:0]  jump_target = '0;
  logic        dmem_ready = 1'b0;

  logic        imem_req, dmem_req, dmem_we;
  logic [7:0]  imem_addr, pc_out;
  logic [15:0] ir_out;
  logic        regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
  logic        retire;
  logic [2:0]  state_out;
`ifdef PERF_CNT_EN
  logic [15:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_sequencer #(.PC_W(8), .IW(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ir_out(ir_out), .pc_out(pc_out),
    .alu_zero(alu_zero), .branch_target(branch_target), .jump_target(jump_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .regdest(regdest), .alusrc(alusrc), .memtoreg(memtoreg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .branch(branch), .jump(jump),
    .retire(retire), .state_out(state_out)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          instr_start = 0;
  int          retire_cyc = -1;
  logic        run_noise_en = 1'b1;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;

  // Static controls {regdest, alusrc, memtoreg, branch, jump} by opcode class.
  function automatic logic [4:0] ctrl5(input logic [3:0] op);
    case (op)
      4'd5, 4'd6:   return 5'b11000;
      4'd7:         return 5'b01100;
      4'd8:         return 5'b01000;
      4'd9:         return 5'b00001;
      4'd10, 4'd11: return 5'b00010;
      default:      return 5'b10000;
    endcase
  endfunction

  // Expected output vector; f = {imem_req, dmem_req, dmem_we, regwrite, memread, memwrite, retire}.
  function automatic logic [46:0] mk(input logic [2:0] st, input logic [4:0] c, input logic [6:0] f);
    return {st, m_pc, m_pc, m_ir, f[6], f[5], f[4], c[4], c[3], c[2], f[3], f[2], f[1],
            c[1], c[0], f[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after a rising edge and put noise on inputs the DUT must ignore.
  task automatic next_cyc();
    @(posedge clk);
    #1;
    cyc++;
    run           = run_noise_en ? 1'($urandom) : 1'b0;
    imem_ready    = 1'($urandom);
    imem_rdata    = 16'($urandom);
    dmem_ready    = 1'($urandom);
    alu_zero      = 1'($urandom);
    branch_target = 8'($urandom);
    jump_target   = 8'($urandom);
  endtask

  // Per-cycle compare of every DUT output against the model, on the falling edge.
  task automatic check_vec(input string ph, input logic [46:0] e);
    logic [46:0] a;
    @(negedge clk);
    a = {state_out, pc_out, imem_addr, ir_out, imem_req, dmem_req, dmem_we, regdest, alusrc,
         memtoreg, regwrite, memread, memwrite, branch, jump, retire};
    if (retire === 1'b1) retire_cyc = cyc;
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL vec_%s cyc=%0d got=%h expected=%h", ph, cyc, a, e);
    end
  endtask

  task automatic idle_cycle(input logic r);
    next_cyc();
    run = r;
    check_vec("idle", mk(3'd0, 5'd0, 7'd0));
  endtask

  task automatic start_run(input int n_idle);
    for (int i = 0; i < n_idle; i++) idle_cycle(1'b0);
    idle_cycle(1'b1);
  endtask

  // One instruction from FETCH to retire. wi/wd are memory wait cycles.
  // abort_at >= 0 pulls reset low in that MEM cycle and returns.
  task automatic do_instr(input logic [15:0] instr, input int wi, input int wd, input logic az,
                          input logic [7:0] tgt, input logic run_after, input int abort_at);
    logic [3:0] op;
    logic [4:0] c;
    logic       is_lw, is_sw, is_br, is_j, ret;
    logic [7:0] pc0;
    op    = instr[3:0];
    c     = ctrl5(op);
    is_lw = (op == 4'd7);
    is_sw = (op == 4'd8);
    is_br = (op == 4'd10) || (op == 4'd11);
    is_j  = (op == 4'd9);
    pc0   = m_pc;
    for (int k = 0; k <= wi; k++) begin
      next_cyc();
      if (k == 0) instr_start = cyc;
      imem_ready = (k == wi);
      if (k == wi) imem_rdata = instr;
      check_vec("fetch", mk(3'd1, 5'd0, 7'b1000000));
    end
    m_ir = instr;
    next_cyc();
    check_vec("decode", mk(3'd2, c, 7'd0));
    next_cyc();
    alu_zero = az;
    if (is_br) begin branch_target = tgt; jump_target = ~tgt; end
    else       begin jump_target = tgt; branch_target = ~tgt; end
    ret = is_br || is_j;
    if (ret) run = run_after;
    check_vec("exec", mk(3'd3, c, {6'd0, ret}));
    if (is_br) m_pc = az ? tgt : m_pc + 8'd1;
    if (is_j)  m_pc = tgt;
    if (is_lw || is_sw) begin
      for (int k = 0; k <= wd; k++) begin
        next_cyc();
        if (k == abort_at) begin
          rst_n = 1'b0;
          #2;
          chk("rst_mid_state", 32'(state_out), 32'd0);
          chk("rst_mid_pc", 32'(pc_out), 32'd0);
          chk("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
          chk("rst_mid_regwrite", 32'(regwrite), 32'd0);
          chk("rst_mid_ir", 32'(ir_out), 32'd0);
          m_pc = 8'h00;
          m_ir = 16'h0000;
          $display("instr ir=%h pc=%h aborted by reset in MEM", instr, pc0);
          return;
        end
        dmem_ready = (k == wd);
        ret = is_sw && (k == wd);
        if (ret) run = run_after;
        check_vec("mem", mk(3'd4, c, {1'b0, 1'b1, is_sw, 1'b0, is_lw, is_sw, ret}));
      end
      if (is_sw) m_pc = m_pc + 8'd1;
    end
    if (!(is_sw || is_br || is_j)) begin
      next_cyc();
      run = run_after;
      check_vec("wb", mk(3'd5, c, 7'b0001001));
      m_pc = m_pc + 8'd1;
    end
    $display("instr ir=%h pc=%h -> %h wi=%0d wd=%0d run_after=%0d", instr, pc0, m_pc, wi, wd,
             run_after);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_pc", 32'(pc_out), 32'd0);
    chk("reset_ir", 32'(ir_out), 32'd0);
    chk("reset_imem_req", 32'(imem_req), 32'd0);
    chk("reset_retire", 32'(retire), 32'd0);
`ifdef PERF_CNT_EN
    chk("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("reset_instr_cnt", 32'(instr_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // R-type, zero wait: 4 cycles, PC 0 -> 1.
    start_run(1);
    do_instr(16'h0000, 0, 0, 1'b0, 8'h00, 1'b0, -1);
    idle_cycle(1'b0);
    chk("r_pc", 32'(pc_out), 32'h01);
    chk("r_latency", 32'(retire_cyc - instr_start + 1), 32'd4);

    // LW with three dmem wait cycles: 8 cycles total.
    start_run(0);
    do_instr(16'h5A37, 0, 3, 1'b0, 8'h00, 1'b0, -1);
    idle_cycle(1'b0);
    chk("lw_pc", 32'(pc_out), 32'h02);
    chk("lw_latency", 32'(retire_cyc - instr_start + 1), 32'd8);

    // BEQ taken and not taken.
    start_run(0);
    do_instr(16'h001A, 0, 0, 1'b1, 8'h40, 1'b0, -1);
    idle_cycle(1'b0);
    chk("br_taken_pc", 32'(pc_out), 32'h40);
    chk("br_latency", 32'(retire_cyc - instr_start + 1), 32'd3);
    start_run(0);
    do_instr(16'h002A, 0, 0, 1'b0, 8'h40, 1'b0, -1);
    idle_cycle(1'b0);
    chk("br_not_taken_pc", 32'(pc_out), 32'h41);

    // Jump to 0xFF, SW wraps PC to 0, then J to 0x10 with run held low.
    start_run(0);
    do_instr(16'h0009, 0, 0, 1'b0, 8'hFF, 1'b0, -1);
    idle_cycle(1'b0);
    chk("j_pc_ff", 32'(pc_out), 32'hFF);
    start_run(0);
    do_instr(16'hC0D8, 1, 1, 1'b0, 8'h00, 1'b0, -1);
    idle_cycle(1'b0);
    chk("sw_wrap_pc", 32'(pc_out), 32'h00);
    chk("sw_latency", 32'(retire_cyc - instr_start + 1), 32'd6);
    start_run(0);
    run_noise_en = 1'b0;
    do_instr(16'h0009, 0, 0, 1'b0, 8'h10, 1'b0, -1);
    run_noise_en = 1'b1;
    idle_cycle(1'b0);
    chk("j_pc_10", 32'(pc_out), 32'h10);
    chk("j_then_idle", 32'(state_out), 32'd0);

    // Reset pulled low in the middle of a MEM wait.
    start_run(0);
    do_instr(16'h0107, 0, 5, 1'b0, 8'h00, 1'b0, 2);
    next_cyc();
    run = 1'b0;
    chk("rst_next_state", 32'(state_out), 32'd0);
    chk("rst_next_dmem_req", 32'(dmem_req), 32'd0);
    rst_n = 1'b1;
    check_vec("after_reset", mk(3'd0, 5'd0, 7'd0));

    // Three back-to-back R instructions, then stop.
    start_run(0);
    do_instr(16'h1230, 0, 0, 1'b0, 8'h00, 1'b1, -1);
    do_instr(16'h456C, 0, 0, 1'b0, 8'h00, 1'b1, -1);
    do_instr(16'h789F, 0, 0, 1'b0, 8'h00, 1'b0, -1);
    idle_cycle(1'b0);
    chk("r3_pc", 32'(pc_out), 32'h03);
`ifdef PERF_CNT_EN
    chk("perf_instr_cnt", 32'(instr_cnt), 32'd3);
    chk("perf_cycle_cnt", 32'(cycle_cnt), 32'd12);
`endif

    // Randomized instruction stream.
    start_run(0);
    for (int i = 0; i < 200; i++) begin
      logic [15:0] instr;
      int          wi, wd;
      logic        ra;
      instr = 16'($urandom);
      wi    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      wd    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      ra    = ($urandom_range(0, 3) != 0);
      do_instr(instr, wi, wd, 1'($urandom), 8'($urandom), ra, -1);
      if (!ra) start_run(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
